// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning N-of-M line decoder.
//
// Contents:
//   state_t      - controller states (IDLE, DIRECT, SCAN)
//   MODE_DIRECT  - mode input value selecting host-addressed operation
//   MODE_SCAN    - mode input value selecting automatic sequencing
//   addr_window  - whether the controller may take a host address in a
//                  given state/mode combination (enable applied separately)
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // A host address is only meaningful while not sequencing and while the
  // mode input asks for direct addressing, so a mode change pending on the
  // next edge already closes the window.
  function automatic logic addr_window(input state_t st, input logic mode);
    return (st != SCAN) && (mode == MODE_DIRECT);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable and output polarity.
//
// Parameters:
//   ADDR_W     - width of the select index; 2**ADDR_W output lines
//   ACTIVE_LOW - 1: selected line 0, others 1; 0: selected line 1, others 0
// Ports:
//   sel   - index of the line to select
//   en    - when low, every line is driven to its inactive level
//   lines - decoded select lines
module onehot_dec #(
  parameter int ADDR_W     = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [ADDR_W-1:0]      sel,
  input  logic                   en,
  output logic [2**ADDR_W-1:0]   lines
);

  localparam int N = 2**ADDR_W;

  logic [N-1:0] hot;

  // Active-high one-hot image first; polarity is applied as a final
  // inversion so the disabled case naturally becomes all-inactive.
  always_comb begin
    hot = '0;
    if (en) begin
      hot[sel] = 1'b1;
    end
  end

  assign lines = ACTIVE_LOW ? ~hot : hot;

endmodule

// File: rtl/decoder_nm_scan.sv
// Registered line decoder that either holds a host-supplied index (DIRECT)
// or steps through all lines on its own with a programmable dwell (SCAN).
//
// Parameters:
//   ADDR_W     - index width; the block drives 2**ADDR_W select lines
//   DWELL_W    - width of the dwell counter and of the dwell input
//   ACTIVE_LOW - 1: selected line driven 0, others 1; 0: inverted
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   e1_n, e2_n - active-low enables
//   e3         - active-high enable (effective enable = e3 & ~e1_n & ~e2_n)
//   mode       - MODE_DIRECT or MODE_SCAN
//   addr_valid - addr carries a new index
//   addr       - requested line index
//   addr_ready - the block takes addr on this edge (combinational)
//   dwell      - extra cycles each line stays selected while scanning
//   y          - registered select lines
//   idx        - currently held index
//   wrap       - one-cycle pulse, aligned with y, when the scan returns to 0
module decoder_nm_scan
  import decoder_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DWELL_W    = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   e1_n,
  input  logic                   e2_n,
  input  logic                   e3,
  input  logic                   mode,
  input  logic                   addr_valid,
  input  logic [ADDR_W-1:0]      addr,
  output logic                   addr_ready,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [2**ADDR_W-1:0]   y,
  output logic [ADDR_W-1:0]      idx,
  output logic                   wrap
);

  localparam int N = 2**ADDR_W;
  localparam logic [N-1:0] Y_OFF = {N{ACTIVE_LOW}};

  state_t              state;
  logic [ADDR_W-1:0]   idx_q;
  logic [DWELL_W-1:0]  cnt;
  logic                wrap_evt;
  logic                wrap_q;
  logic [N-1:0]        y_q;

  logic                en;
  logic                accept;
  logic                dec_en;
  logic [N-1:0]        dec_lines;

  assign en         = e3 & ~e1_n & ~e2_n;
  assign addr_ready = en & addr_window(state, mode);
  assign accept     = addr_valid & addr_ready;

  // Lines stay inactive until the controller has left IDLE at least once.
  assign dec_en = en & (state != IDLE);

  onehot_dec #(
    .ADDR_W     (ADDR_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .sel   (idx_q),
    .en    (dec_en),
    .lines (dec_lines)
  );

  // Controller, index, dwell counter and output registers.
  // y samples the decode of the index held before this edge, which gives the
  // one-cycle lag between an index change and the lines. wrap_evt marks the
  // edge on which the scan rolled over; it is delayed once more into wrap so
  // the pulse lines up with y showing line 0. With en low everything except
  // the output registers is frozen in place.
  // The dwell test uses >= so that lowering dwell below the current count
  // forces an advance on the very next edge instead of waiting for the
  // counter to roll around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx_q    <= '0;
      cnt      <= '0;
      wrap_evt <= 1'b0;
      wrap_q   <= 1'b0;
      y_q      <= Y_OFF;
    end else begin
      y_q      <= dec_lines;
      wrap_q   <= wrap_evt;
      wrap_evt <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            state <= (mode == MODE_SCAN) ? SCAN : DIRECT;
            cnt   <= '0;
            if (accept) begin
              idx_q <= addr;
            end
          end
          DIRECT: begin
            if (mode == MODE_SCAN) begin
              state <= SCAN;
              cnt   <= '0;
            end else if (accept) begin
              idx_q <= addr;
            end
          end
          SCAN: begin
            if (mode == MODE_DIRECT) begin
              state <= DIRECT;
              cnt   <= '0;
            end else if (cnt >= dwell) begin
              idx_q    <= idx_q + ADDR_W'(1);
              cnt      <= '0;
              wrap_evt <= (idx_q == {ADDR_W{1'b1}});
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nm_scan.sv
// Self-checking bench for decoder_nm_scan.
// A reference model advances once per clock edge from the inputs present at
// that edge and queues the outputs it expects; a monitor on the falling edge
// pops and compares. Directed sequences cover the documented scenarios, then
// randomized traffic follows. A second instance (ADDR_W=4, active-high
// lines) covers the wide/inverted configuration.
module tb_decoder_nm_scan;

  localparam int NL = 8;
  localparam int P_IDLE   = 0;
  localparam int P_DIRECT = 1;
  localparam int P_SCAN   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        e1_n = 1'b1, e2_n = 1'b1, e3 = 1'b0, mode = 1'b0, addr_valid = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] dwell = '0;
  logic        addr_ready;
  logic [7:0]  y;
  logic [2:0]  idx;
  logic        wrap;

  logic        b_rst = 1'b1, b_e1_n = 1'b0, b_e2_n = 1'b0, b_e3 = 1'b0;
  logic        b_mode = 1'b0, b_av = 1'b0;
  logic [3:0]  b_addr = '0;
  logic [15:0] b_dwell = '0;
  logic        b_ready;
  logic [15:0] b_y;
  logic [3:0]  b_idx;
  logic        b_wrap;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic       ready;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state
  int   m_phase;
  int   m_idx;
  int   m_held;
  bit   m_wrap;
  bit   m_wrap_next;
  logic [7:0] m_y;

  decoder_nm_scan dut (
    .clk(clk), .rst(rst), .e1_n(e1_n), .e2_n(e2_n), .e3(e3), .mode(mode),
    .addr_valid(addr_valid), .addr(addr), .addr_ready(addr_ready),
    .dwell(dwell), .y(y), .idx(idx), .wrap(wrap)
  );

  decoder_nm_scan #(.ADDR_W(4), .DWELL_W(16), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .e1_n(b_e1_n), .e2_n(b_e2_n), .e3(b_e3), .mode(b_mode),
    .addr_valid(b_av), .addr(b_addr), .addr_ready(b_ready),
    .dwell(b_dwell), .y(b_y), .idx(b_idx), .wrap(b_wrap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] line_of(input int i);
    logic [7:0] v;
    v = 8'd1 << i;
    return ~v;
  endfunction

  task automatic modelReset();
    m_phase = P_IDLE;
    m_idx = 0;
    m_held = 0;
    m_wrap = 0;
    m_wrap_next = 0;
    m_y = 8'hFF;
  endtask

  // One clock edge of the intended behaviour, using the inputs held at it.
  task automatic modelEdge();
    bit en_s;
    bit ready;
    if (rst) return;
    en_s  = e3 && !e1_n && !e2_n;
    ready = en_s && (m_phase != P_SCAN) && (mode == 1'b0);
    m_y = (en_s && m_phase != P_IDLE) ? line_of(m_idx) : 8'hFF;
    m_wrap = m_wrap_next;
    m_wrap_next = 0;
    if (!en_s) return;
    if (m_phase == P_IDLE) begin
      m_phase = mode ? P_SCAN : P_DIRECT;
      m_held = 0;
      if (ready && addr_valid) m_idx = addr;
    end else if (m_phase == P_DIRECT) begin
      if (mode) begin
        m_phase = P_SCAN;
        m_held = 0;
      end else if (addr_valid) begin
        m_idx = addr;
      end
    end else begin
      if (!mode) begin
        m_phase = P_DIRECT;
        m_held = 0;
      end else if (m_held >= int'(dwell)) begin
        m_idx = (m_idx + 1) % NL;
        m_held = 0;
        m_wrap_next = (m_idx == 0);
      end else begin
        m_held++;
      end
    end
  endtask

  // Advance one cycle: let the model take the edge, drive new inputs just
  // after it, and queue the outputs expected for the rest of the cycle.
  task automatic applyStimulus(input logic r, input logic e1, input logic e2, input logic e3v,
                               input logic md, input logic av, input logic [2:0] a,
                               input logic [15:0] dw);
    exp_t e;
    @(posedge clk);
    #1;
    modelEdge();
    rst = r; e1_n = e1; e2_n = e2; e3 = e3v; mode = md;
    addr_valid = av; addr = a; dwell = dw;
    if (r) modelReset();
    e.y = m_y;
    e.idx = 3'(m_idx);
    e.wrap = m_wrap;
    e.ready = (e3v && !e1 && !e2) && (m_phase != P_SCAN) && (md == 1'b0);
    exp_q.push_back(e);
  endtask

  // Monitor: compare whatever the model queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("sb_y", 32'(y), 32'(mon_e.y));
      checkOutput("sb_idx", 32'(idx), 32'(mon_e.idx));
      checkOutput("sb_wrap", 32'(wrap), 32'(mon_e.wrap));
      checkOutput("sb_ready", 32'(addr_ready), 32'(mon_e.ready));
    end
  end

  initial begin
    int idx_hist[$];
    int wrap_pos[$];
    int wrap_hits;
    int bad_steps;
    int run_len;
    int runs_val[$];
    int runs_len[$];
    logic [7:0] y_at_wrap;
    logic cur_md;
    logic [15:0] cur_dw;

    modelReset();

    // Reset state
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("reset_y", 32'(y), 32'hFF);
    checkOutput("reset_idx", 32'(idx), 0);
    checkOutput("reset_wrap", 32'(wrap), 0);

    // Direct address 5, two-edge latency to y
    applyStimulus(0, 0, 0, 1, 0, 1, 3'd5, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 3'd0, 0);
    checkOutput("accept_idx", 32'(idx), 5);
    checkOutput("accept_y_lag", 32'(y), 32'hFF);
    applyStimulus(0, 0, 0, 1, 0, 0, 3'd0, 0);
    checkOutput("direct5_y", 32'(y), 32'b1101_1111);

    // Disable via e2_n for three cycles
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("dis_y", 32'(y), 32'hFF);
    checkOutput("dis_idx", 32'(idx), 5);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("dis_hold_idx", 32'(idx), 5);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("reen_y", 32'(y), 32'b1101_1111);

    // Scan from 6 with dwell 2
    applyStimulus(0, 0, 0, 1, 0, 1, 3'd6, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 16'd2);
    checkOutput("scan_start_idx", 32'(idx), 6);
    wrap_hits = 0;
    y_at_wrap = 8'h00;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 16'd2);
      idx_hist.push_back(int'(idx));
      if (wrap) begin
        wrap_hits++;
        y_at_wrap = y;
      end
    end
    run_len = 0;
    foreach (idx_hist[i]) begin
      if (i > 0 && idx_hist[i] != idx_hist[i-1]) begin
        runs_val.push_back(idx_hist[i-1]);
        runs_len.push_back(run_len);
        run_len = 0;
      end
      run_len++;
    end
    if (runs_val.size() >= 4) begin
      checkOutput("scan_seq0", 32'(runs_val[0]), 6);
      checkOutput("scan_seq1", 32'(runs_val[1]), 7);
      checkOutput("scan_seq2", 32'(runs_val[2]), 0);
      checkOutput("scan_seq3", 32'(runs_val[3]), 1);
      checkOutput("scan_run7", 32'(runs_len[1]), 3);
      checkOutput("scan_run0", 32'(runs_len[2]), 3);
    end else begin
      checkOutput("scan_runs", 32'(runs_val.size()), 4);
    end
    checkOutput("scan_wrap_hits", 32'(wrap_hits), 1);
    checkOutput("scan_wrap_y", 32'(y_at_wrap), 32'hFE);

    // Dwell 0: advance every cycle
    idx_hist.delete();
    for (int i = 0; i < 22; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 16'd0);
      idx_hist.push_back(int'(idx));
      if (wrap && i >= 3) wrap_pos.push_back(i);
    end
    bad_steps = 0;
    for (int i = 4; i < idx_hist.size(); i++) begin
      if (idx_hist[i] != (idx_hist[i-1] + 1) % NL) bad_steps++;
    end
    checkOutput("dwell0_steps", 32'(bad_steps), 0);
    if (wrap_pos.size() >= 2) begin
      checkOutput("wrap_period", 32'(wrap_pos[1] - wrap_pos[0]), 8);
    end else begin
      checkOutput("wrap_count", 32'(wrap_pos.size()), 2);
    end

    // Reach idx 3 mid-dwell, then asynchronous reset
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 16'd20);
    applyStimulus(0, 0, 0, 1, 0, 1, 3'd3, 16'd20);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 16'd20);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0, 16'd20);
    checkOutput("pre_rst_idx", 32'(idx), 3);
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 16'd20);
    #1;
    checkOutput("async_rst_y", 32'(y), 32'hFF);
    checkOutput("async_rst_idx", 32'(idx), 0);
    checkOutput("async_rst_wrap", 32'(wrap), 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 16'd1);

    // Randomized traffic against the model
    cur_md = 1'b1;
    cur_dw = 16'd1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) cur_md = ~cur_md;
      if ($urandom_range(0, 14) == 0) cur_dw = 16'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 249) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) != 0),
                    cur_md,
                    1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)),
                    cur_dw);
    end

    // Wide, active-high instance
    @(posedge clk); #1;
    b_rst = 1'b0; b_e3 = 1'b1; b_mode = 1'b0; b_av = 1'b1; b_addr = 4'd15;
    @(posedge clk); #1;
    b_av = 1'b0;
    checkOutput("b_idx15", 32'(b_idx), 15);
    @(posedge clk); #1;
    checkOutput("b_y15", 32'(b_y), 32'h8000);
    b_mode = 1'b1; b_dwell = 16'd100; b_av = 1'b1; b_addr = 4'd2;
    #1;
    checkOutput("b_ready_modechg", 32'(b_ready), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("b_ready_scan", 32'(b_ready), 0);
    checkOutput("b_idx_scan", 32'(b_idx), 15);
    checkOutput("b_y_scan", 32'(b_y), 32'h8000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) checkOutput("drain", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
